score_keeper: RTL and testbench
===============================

# score_keeper

Match scoring controller for the two-player tug-of-war game. It reads the 7-bit `winner` display code that the round-victory detector drives and keeps a per-player round tally. When a round ends, it holds the result on screen for a fixed time, then pulses a round restart back to the playfield and detector. It declares the match over when a player reaches the target score.

## Interface
- `WIN_TARGET`, default 3: rounds needed to win the match; legal range 1–9.
- `HOLD_CYCLES`, default 50: cycles a round result is held before restart; must be ≥1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `winner` input 7: display code from the victory detector. `7'b1110111` = no winner, `7'b0001000` = left won, `7'b1000111` = right won; any other value is invalid.
- `round_reset` output 1: one-cycle active-high synchronous reset to the playfield and victory detector.
- `left_score_hex` output 7: left score display; format set by configuration.
- `right_score_hex` output 7: right score display; format set by configuration.
- `match_over` output 1: high once either score reaches `WIN_TARGET`.
- `match_winner` output 2: `01` = left, `10` = right, `00` = undecided.

## Operation
- Registers:
  - 4-bit `left_score` and 4-bit `right_score`.
  - Hold counter, width `$clog2(HOLD_CYCLES)+1`.
  - FSM state.
- IDLE:
  - Left code: `left_score`+1. Go to DONE if the new value equals `WIN_TARGET`, else go to HOLD with the counter cleared.
  - Right code: symmetric.
  - No-winner or invalid code: stay in IDLE; no score change.
- HOLD: counter increments each cycle. When the counter equals `HOLD_CYCLES-1`, go to RESTART. `winner` is ignored.
- RESTART: `round_reset`=1 for exactly this one cycle, then go to WAIT_CLEAR.
- WAIT_CLEAR: stay until `winner` equals the no-winner code, then go to IDLE. A win code still present here is never counted again.
- DONE: terminal state.
  - `match_over`=1; `match_winner` names the player who reached the target.
  - `round_reset` stays 0; scores are frozen.
  - Only `reset` exits DONE.
- Each win is counted exactly once, however many cycles the code persists.
- Scores never exceed `WIN_TARGET`. The two win codes are mutually exclusive, so there is no simultaneous-win case.
- Outputs decode combinationally from registers (Moore): `round_reset`, `match_over`, `match_winner`, and both hex outputs.

## Timing
- Reset asserted (low), asynchronously:
  - State = IDLE; scores = 0; counter = 0.
  - `round_reset`=0, `match_over`=0, `match_winner`=`00`.
  - Hex outputs show 0 (`7'b1000000` with the macro, `7'b0000000` without).
- Reset mid-HOLD or mid-RESTART: `round_reset` drops to 0 at once, and no restart pulse follows.
- Win code first sampled at edge k:
  - The score display updates after edge k.
  - `round_reset` is high in cycle k+`HOLD_CYCLES`+1 (between edges k+`HOLD_CYCLES` and k+`HOLD_CYCLES`+1).
- The detector clears on the edge that ends the `round_reset` cycle. The earliest return to IDLE is the following edge.
- Final win at edge k: `match_over` is high after edge k.

## Configuration
- `SCORE_HEX_EN` defined:
  - Each hex output is the active-low 7-segment digit of its score.
  - Digits 0–9 = `1000000`, `1111001`, `0100100`, `0110000`, `0011001`, `0010010`, `0000010`, `1111000`, `0000000`, `0010000`.
- `SCORE_HEX_EN` undefined: each hex output is `{3'b000, score}` as raw binary, for bench and LED use.

## Test plan
Benches use `WIN_TARGET`=3, `HOLD_CYCLES`=4.
- Reset, `winner`=`1110111` for 10 cycles → scores 0, `round_reset` never high, `match_over`=0.
- Left code held 20 cycles, then no-winner → `left_score`=1 (hex `1111001`); exactly one `round_reset` pulse, 5 cycles after the first sample; no second count.
- Right code three separate times, each cleared after `round_reset` → `right_score`=3, `match_over`=1, `match_winner`=`10`. No `round_reset` after the third win; further codes are ignored.
- Invalid code `7'b0000000` for 10 cycles in IDLE → no score change, no pulse.
- Left win, then `reset` pulled low during HOLD cycle 2 → immediate all-zero outputs, no `round_reset`; a left win after release counts as `left_score`=1.
- Build without `SCORE_HEX_EN`, two left wins → `left_score_hex`=`7'b0000010`.

Source files
------------

// File: rtl/score_keeper_if.sv
// Signal bundle between score_keeper and the playfield / victory-detector side.
// The game side is the master; score_keeper attaches through the slave modport.
interface score_keeper_if;
    logic [6:0] winner;
    logic       round_reset;
    logic [6:0] left_score_hex;
    logic [6:0] right_score_hex;
    logic       match_over;
    logic [1:0] match_winner;

    modport master (
        output winner,
        input  round_reset, left_score_hex, right_score_hex, match_over, match_winner
    );

    modport slave (
        input  winner,
        output round_reset, left_score_hex, right_score_hex, match_over, match_winner
    );
endinterface

// File: rtl/score_keeper.sv
// Tug-of-war match scoring controller: counts round wins, holds each result, then pulses round_reset.
// Optional macro SCORE_HEX_EN selects active-low 7-segment score digits instead of raw binary.
module score_keeper #(
    parameter int unsigned WIN_TARGET  = 3,
    parameter int unsigned HOLD_CYCLES = 50
) (
    input  logic          clk,
    input  logic          reset,
    score_keeper_if.slave bus
);
    localparam int unsigned CW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [6:0] CODE_NONE  = 7'b1110111;
    localparam logic [6:0] CODE_LEFT  = 7'b0001000;
    localparam logic [6:0] CODE_RIGHT = 7'b1000111;
    localparam logic [3:0] TARGET     = 4'(WIN_TARGET);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RESTART,
        S_WAIT_CLEAR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    left_q, left_d;
    logic [3:0]    right_q, right_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.winner == CODE_LEFT) begin
                    left_d = left_q + 4'd1;
                    if (left_d == TARGET) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end else if (bus.winner == CODE_RIGHT) begin
                    right_d = right_q + 4'd1;
                    if (right_d == TARGET) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                state_d = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                // A lingering win code is deliberately not re-counted here.
                if (bus.winner == CODE_NONE) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef SCORE_HEX_EN
    function automatic logic [6:0] score_disp(input logic [3:0] s);
        case (s)
            4'd0:    score_disp = 7'b1000000;
            4'd1:    score_disp = 7'b1111001;
            4'd2:    score_disp = 7'b0100100;
            4'd3:    score_disp = 7'b0110000;
            4'd4:    score_disp = 7'b0011001;
            4'd5:    score_disp = 7'b0010010;
            4'd6:    score_disp = 7'b0000010;
            4'd7:    score_disp = 7'b1111000;
            4'd8:    score_disp = 7'b0000000;
            4'd9:    score_disp = 7'b0010000;
            default: score_disp = 7'b1111111;
        endcase
    endfunction
`else
    function automatic logic [6:0] score_disp(input logic [3:0] s);
        score_disp = {3'b000, s};
    endfunction
`endif

    always_comb begin
        bus.round_reset     = (state_q == S_RESTART);
        bus.match_over      = (state_q == S_DONE);
        bus.match_winner    = 2'b00;
        bus.left_score_hex  = score_disp(left_q);
        bus.right_score_hex = score_disp(right_q);
        if (state_q == S_DONE) begin
            bus.match_winner = (left_q == TARGET) ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper (WIN_TARGET=3, HOLD_CYCLES=4) against a round-level scoring model.
// Honours SCORE_HEX_EN the same way as the design build.
module tb_score_keeper;
    localparam int unsigned T = 3;
    localparam int unsigned H = 4;
    localparam logic [6:0] CODE_NONE  = 7'b1110111;
    localparam logic [6:0] CODE_LEFT  = 7'b0001000;
    localparam logic [6:0] CODE_RIGHT = 7'b1000111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_keeper_if bus();

    score_keeper #(.WIN_TARGET(T), .HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int ml = 0;
    int mr = 0;

    function automatic logic [6:0] hex_of(input int s);
`ifdef SCORE_HEX_EN
        case (s)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
`else
        return 7'(s);
`endif
    endfunction

    function automatic logic [1:0] exp_mw();
        if (ml == int'(T)) return 2'b01;
        if (mr == int'(T)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [6:0] rand_non_win();
        logic [6:0] v;
        v = 7'($urandom);
        if (v == CODE_LEFT || v == CODE_RIGHT) v = 7'b0000000;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        bus.winner = CODE_NONE;
        step();
        step();
        reset = 1'b1;
        ml = 0;
        mr = 0;
    endtask

    // One round from IDLE: win code held for hold_len sampling edges, then cleared.
    task automatic run_round(input bit left_side, input int hold_len);
        bit final_win;
        int pulses;
        pulses = 0;
        bus.winner = left_side ? CODE_LEFT : CODE_RIGHT;
        if (left_side) ml++; else mr++;
        final_win = (ml == int'(T)) || (mr == int'(T));
        for (int i = 1; i <= hold_len; i++) begin
            step();
            n_total++;
            if (bus.left_score_hex !== hex_of(ml)) begin
                n_bad++;
                $display("FAIL round_left_hex cyc=%0d got=%b exp=%b", i, bus.left_score_hex, hex_of(ml));
            end
            n_total++;
            if (bus.right_score_hex !== hex_of(mr)) begin
                n_bad++;
                $display("FAIL round_right_hex cyc=%0d got=%b exp=%b", i, bus.right_score_hex, hex_of(mr));
            end
            n_total++;
            if (bus.round_reset !== (!final_win && i == int'(H) + 1)) begin
                n_bad++;
                $display("FAIL round_reset_timing cyc=%0d got=%b exp=%b", i, bus.round_reset,
                         (!final_win && i == int'(H) + 1));
            end
            n_total++;
            if (bus.match_over !== final_win || bus.match_winner !== exp_mw()) begin
                n_bad++;
                $display("FAIL round_match cyc=%0d got=%b/%b exp=%b/%b", i, bus.match_over,
                         bus.match_winner, final_win, exp_mw());
            end
            if (bus.round_reset === 1'b1) pulses++;
        end
        bus.winner = CODE_NONE;
        if (!final_win) begin
            step();
            if (bus.round_reset === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != (final_win ? 0 : 1)) begin
            n_bad++;
            $display("FAIL round_pulse_count got=%0d exp=%0d", pulses, final_win ? 0 : 1);
        end
    endtask

    // Drives non-win codes and checks that nothing moves.
    task automatic idle_noise(input int cycles, input bit use_zero);
        for (int i = 0; i < cycles; i++) begin
            bus.winner = use_zero ? 7'b0000000 : rand_non_win();
            step();
            n_total++;
            if (bus.left_score_hex !== hex_of(ml) || bus.right_score_hex !== hex_of(mr)
                || bus.round_reset !== 1'b0 || bus.match_over !== (exp_mw() != 2'b00)
                || bus.match_winner !== exp_mw()) begin
                n_bad++;
                $display("FAIL noise_stable cyc=%0d got=%b,%b,%b,%b,%b exp=%b,%b,0,%b,%b", i,
                         bus.left_score_hex, bus.right_score_hex, bus.round_reset, bus.match_over,
                         bus.match_winner, hex_of(ml), hex_of(mr), (exp_mw() != 2'b00), exp_mw());
            end
        end
        bus.winner = CODE_NONE;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.winner = CODE_NONE;
        #3;
        n_total++;
        if (bus.left_score_hex !== hex_of(0) || bus.right_score_hex !== hex_of(0)
            || bus.round_reset !== 1'b0 || bus.match_over !== 1'b0 || bus.match_winner !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state got=%b,%b,%b,%b,%b exp=%b,%b,0,0,00", bus.left_score_hex,
                     bus.right_score_hex, bus.round_reset, bus.match_over, bus.match_winner,
                     hex_of(0), hex_of(0));
        end
        step();
        reset = 1'b1;
        ml = 0;
        mr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++;
            if (bus.left_score_hex !== hex_of(0) || bus.right_score_hex !== hex_of(0)
                || bus.round_reset !== 1'b0 || bus.match_over !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%b,%b,%b,%b", i, bus.left_score_hex,
                         bus.right_score_hex, bus.round_reset, bus.match_over);
            end
        end
    endtask

    task automatic test_single_left();
        do_reset();
        run_round(1'b1, 20);
        idle_noise(6, 1'b0);
    endtask

    task automatic test_right_match();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            run_round(1'b0, int'($urandom_range(H + 2, H + 8)));
        end
        n_total++;
        if (bus.match_over !== 1'b1 || bus.match_winner !== 2'b10 || bus.right_score_hex !== hex_of(3)) begin
            n_bad++;
            $display("FAIL right_match_end got=%b,%b,%b exp=1,10,%b", bus.match_over,
                     bus.match_winner, bus.right_score_hex, hex_of(3));
        end
        for (int i = 0; i < 4; i++) begin
            bus.winner = ($urandom_range(0, 1) == 0) ? CODE_LEFT : CODE_RIGHT;
            step();
        end
        idle_noise(8, 1'b0);
    endtask

    task automatic test_invalid();
        do_reset();
        idle_noise(10, 1'b1);
        idle_noise(10, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        bus.winner = CODE_LEFT;
        step();
        step();
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.left_score_hex !== hex_of(0) || bus.right_score_hex !== hex_of(0)
            || bus.round_reset !== 1'b0 || bus.match_over !== 1'b0 || bus.match_winner !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_hold_reset got=%b,%b,%b,%b,%b exp=%b,%b,0,0,00", bus.left_score_hex,
                     bus.right_score_hex, bus.round_reset, bus.match_over, bus.match_winner,
                     hex_of(0), hex_of(0));
        end
        bus.winner = CODE_NONE;
        step();
        reset = 1'b1;
        ml = 0;
        mr = 0;
        idle_noise(2 * int'(H) + 2, 1'b0);
        run_round(1'b1, int'(H) + 2);
        n_total++;
        if (bus.left_score_hex !== hex_of(1)) begin
            n_bad++;
            $display("FAIL after_reset_win got=%b exp=%b", bus.left_score_hex, hex_of(1));
        end
    endtask

    task automatic test_reset_mid_restart();
        do_reset();
        bus.winner = CODE_LEFT;
        for (int i = 0; i <= int'(H); i++) step();
        n_total++;
        if (bus.round_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_reached got=%b exp=1", bus.round_reset);
        end
        reset = 1'b0;
        bus.winner = CODE_NONE;
        #1;
        n_total++;
        if (bus.round_reset !== 1'b0 || bus.left_score_hex !== hex_of(0)) begin
            n_bad++;
            $display("FAIL mid_restart_reset got=%b,%b exp=0,%b", bus.round_reset,
                     bus.left_score_hex, hex_of(0));
        end
        step();
        reset = 1'b1;
        ml = 0;
        mr = 0;
        idle_noise(int'(H) + 3, 1'b0);
    endtask

    task automatic test_two_left();
        logic [6:0] exp_two;
`ifdef SCORE_HEX_EN
        exp_two = 7'b0100100;
`else
        exp_two = 7'b0000010;
`endif
        do_reset();
        run_round(1'b1, int'(H) + 2);
        run_round(1'b1, int'(H) + 5);
        n_total++;
        if (bus.left_score_hex !== exp_two) begin
            n_bad++;
            $display("FAIL two_left_hex got=%b exp=%b", bus.left_score_hex, exp_two);
        end
    endtask

    task automatic test_random_matches();
        for (int m = 0; m < 5; m++) begin
            do_reset();
            while (exp_mw() == 2'b00) begin
                idle_noise(int'($urandom_range(0, 3)), 1'b0);
                run_round($urandom_range(0, 1) == 1, int'($urandom_range(H + 2, H + 9)));
            end
            idle_noise(5, 1'b0);
        end
    endtask

    initial begin
        bus.winner = CODE_NONE;
        reset      = 1'b1;
        test_reset();
        test_single_left();
        test_right_match();
        test_invalid();
        test_reset_mid_hold();
        test_reset_mid_restart();
        test_two_left();
        test_random_matches();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
